fifo_ctrl: RTL



---
 rtl/fifo_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a circular first-word-fall-through FIFO built on an
// external 2**ADDR_WIDTH-entry register file with a registered write port.
module fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  push;
   logic                  pop;

   // A push into a full FIFO is accepted when a pop frees the slot in the same cycle
   always_comb begin
      push = wr & (~full | rd);
      pop  = rd & ~empty;
   end

   assign w_en   = push;
   assign w_addr = w_ptr;
   assign r_addr = r_ptr;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (32'(count) >= AF_LEVEL);
   assign almost_empty = (32'(count) <= AE_LEVEL);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push) w_ptr <= w_ptr + ADDR_WIDTH'(1);
         if (pop)  r_ptr <= r_ptr + ADDR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
            default: count <= count;
         endcase
         // Setting an error outranks clearing it in the same cycle
         if (wr & full & ~rd) overflow <= 1'b1;
         else if (clr_err)    overflow <= 1'b0;
         if (rd & empty)      underflow <= 1'b1;
         else if (clr_err)    underflow <= 1'b0;
      end
   end

endmodule
